msk_hpc3_rnd_gen: RTL and testbench

MSK_HPC3_RND_GEN -- requirements
Module: msk_hpc3_rnd_gen

---
 rtl/msk_hpc3_rnd_gen_pkg.sv | 24 ++
 rtl/xorshift128_core.sv | 57 +++++
 rtl/msk_hpc3_rnd_gen.sv | 96 +++++++++
 tb/tb_msk_hpc3_rnd_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/msk_hpc3_rnd_gen_pkg.sv
// Shared types and constants for the HPC3 gadget randomness generator.
// Covers the bus-width rule, FSM states, lane-mixing constant and default warmup length.
package msk_hpc3_rnd_gen_pkg;

    localparam int          DEFAULT_WARMUP = 16;
    localparam logic [31:0] LANE_MIX       = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_LOAD,
        ST_WARMUP,
        ST_RUN
    } state_e;

    // Two HPC3 randomness groups of 2*d*(d-1) bits each.
    function automatic int rnd_width(input int shares);
        return 4 * shares * (shares - 1);
    endfunction

    function automatic logic [31:0] lane_mix(input int idx);
        return 32'(idx) * LANE_MIX;
    endfunction

endpackage

// File: rtl/xorshift128_core.sv
// One xorshift128 generator lane-set with seed load and step enable.
// w_next_o is the w value the next step produces, so the owner can capture it on the stepping edge.
module xorshift128_core
    import msk_hpc3_rnd_gen_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [127:0] seed_i,
    input  logic         step_i,
    output logic [31:0]  w_next_o
);

    localparam logic [31:0] MIX = lane_mix(IDX);

    logic [31:0] x_q, y_q, z_q, w_q;
    logic [31:0] x_seed, y_seed, z_seed, w_seed;
    logic [31:0] t, w_d;

    always_comb begin
        x_seed = seed_i[31:0]   ^ MIX;
        y_seed = seed_i[63:32]  ^ MIX;
        z_seed = seed_i[95:64]  ^ MIX;
        w_seed = seed_i[127:96] ^ MIX;
        // An all-zero state is the one fixed point of xorshift; steer away from it.
        if ({x_seed, y_seed, z_seed, w_seed} == 128'h0) begin
            w_seed = 32'd1;
        end
        t   = x_q ^ (x_q << 11);
        w_d = w_q ^ (w_q >> 19) ^ t ^ (t >> 8);
    end

    // NOTE: state registers use non-blocking assignments and an async reset so every lane clears without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            w_q <= '0;
        end else if (load_i) begin
            x_q <= x_seed;
            y_q <= y_seed;
            z_q <= z_seed;
            w_q <= w_seed;
        end else if (step_i) begin
            x_q <= y_q;
            y_q <= z_q;
            z_q <= w_q;
            w_q <= w_d;
        end
    end

    assign w_next_o = w_d;

endmodule

// File: rtl/msk_hpc3_rnd_gen.sv
// Randomness source for an HPC3 GF(4) multiplier: parallel xorshift128 cores behind a
// seed/warmup FSM and a valid/ready output register delivering one fresh word per cycle.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_hpc3_rnd_gen
    import msk_hpc3_rnd_gen_pkg::*;
#(
    parameter int d      = `DEFAULTSHARES,
    parameter int WARMUP = DEFAULT_WARMUP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        seed_valid_i,
    input  logic [127:0]                seed_i,
    output logic [rnd_width(d)-1:0]     rnd_o,
    output logic                        rnd_valid_o,
    input  logic                        rnd_ready_i,
    output logic                        busy_o
);

    localparam int RNDW = rnd_width(d);
    localparam int NC   = (RNDW + 31) / 32;
    localparam int CW   = $clog2(WARMUP + 1);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [RNDW-1:0]   rnd_q;
    logic              rnd_valid_q;
    logic              busy_q;
    logic              fire;
    logic              core_step;
    logic [NC*32-1:0]  core_w;

    assign fire      = rnd_valid_q & rnd_ready_i;
    assign core_step = (state_q == ST_WARMUP) | fire;

    for (genvar k = 0; k < NC; k++) begin : g_core
        xorshift128_core #(
            .IDX(k)
        ) u_core (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (seed_valid_i),
            .seed_i  (seed_i),
            .step_i  (core_step),
            .w_next_o(core_w[k*32 +: 32])
        );
    end

    // Cores load on the seed_valid edge; a reseed overrides any step, including a simultaneous fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNSEEDED;
            cnt_q       <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (seed_valid_i) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_WARMUP;
                end
                ST_WARMUP: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WARMUP - 1)) begin
                        rnd_q       <= RNDW'(core_w);
                        rnd_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        rnd_q <= RNDW'(core_w);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rnd_o       = rnd_q;
    assign rnd_valid_o = rnd_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_msk_hpc3_rnd_gen.sv
// Scoreboard bench for msk_hpc3_rnd_gen at d=2, 3 and 4 driven in lockstep from one
// two-core xorshift128 reference model.
module tb_msk_hpc3_rnd_gen;

    localparam int WARMUP = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         seed_valid_i;
    logic [127:0] seed_i;
    logic         rnd_ready_i;
    logic [7:0]   rnd2;
    logic [23:0]  rnd3;
    logic [47:0]  rnd4;
    logic         v2, v3, v4, b2, b3, b4;

    always #5 clk = ~clk;

    msk_hpc3_rnd_gen #(.d(2), .WARMUP(WARMUP)) dut2 (
        .clk(clk), .rst_n(rst_n), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .rnd_o(rnd2), .rnd_valid_o(v2), .rnd_ready_i(rnd_ready_i), .busy_o(b2));
    msk_hpc3_rnd_gen #(.d(3), .WARMUP(WARMUP)) dut3 (
        .clk(clk), .rst_n(rst_n), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .rnd_o(rnd3), .rnd_valid_o(v3), .rnd_ready_i(rnd_ready_i), .busy_o(b3));
    msk_hpc3_rnd_gen #(.d(4), .WARMUP(WARMUP)) dut4 (
        .clk(clk), .rst_n(rst_n), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .rnd_o(rnd4), .rnd_valid_o(v4), .rnd_ready_i(rnd_ready_i), .busy_o(b4));

    typedef struct {
        logic [31:0] x, y, z, w;
    } lanes_t;

    lanes_t      mc[2];
    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_seed(input logic [127:0] s);
        logic [31:0] mix;
        for (int k = 0; k < 2; k++) begin
            mix = 32'h9E3779B9 * 32'(k);
            mc[k].x = s[31:0]   ^ mix;
            mc[k].y = s[63:32]  ^ mix;
            mc[k].z = s[95:64]  ^ mix;
            mc[k].w = s[127:96] ^ mix;
            if (mc[k].x == 0 && mc[k].y == 0 && mc[k].z == 0 && mc[k].w == 0) mc[k].w = 32'd1;
        end
    endfunction

    function automatic logic [63:0] model_step();
        logic [31:0] t;
        for (int k = 0; k < 2; k++) begin
            t       = mc[k].x ^ (mc[k].x << 11);
            mc[k].x = mc[k].y;
            mc[k].y = mc[k].z;
            mc[k].z = mc[k].w;
            mc[k].w = mc[k].w ^ (mc[k].w >> 19) ^ t ^ (t >> 8);
        end
        return {mc[1].w, mc[0].w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input logic [63:0] e);
        check("rnd_d2", 64'(rnd2), {56'h0, e[7:0]});
        check("rnd_d3", 64'(rnd3), {40'h0, e[23:0]});
        check("rnd_d4", 64'(rnd4), {16'h0, e[47:0]});
    endtask

    task automatic check_flags(input logic valid_e, input logic busy_e);
        check("valid_d2", 64'(v2), 64'(valid_e));
        check("valid_d3", 64'(v3), 64'(valid_e));
        check("valid_d4", 64'(v4), 64'(valid_e));
        check("busy_d2",  64'(b2), 64'(busy_e));
        check("busy_d3",  64'(b3), 64'(busy_e));
        check("busy_d4",  64'(b4), 64'(busy_e));
    endtask

    // One RUN cycle: the presented word must equal the scoreboard head; a fire retires it.
    task automatic run_cycle(input logic rdy);
        rnd_ready_i = rdy;
        check_flags(1'b1, 1'b0);
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected word queued at %0t", $time);
            $fatal(1, "scoreboard underrun");
        end
        check_word(exp_q[0]);
        if (rdy) begin
            void'(exp_q.pop_front());
            exp_q.push_back(model_step());
        end
        step();
    endtask

    // Pulse seed_valid (optionally with a fire), walk the busy window, then queue the first word.
    task automatic do_seed(input logic [127:0] s, input logic rdy);
        seed_i       = s;
        seed_valid_i = 1'b1;
        rnd_ready_i  = rdy;
        if (v2 && rdy && exp_q.size() != 0) begin
            check_word(exp_q[0]);
            void'(exp_q.pop_front());
        end
        step();
        seed_valid_i = 1'b0;
        seed_i       = ~s;
        rnd_ready_i  = 1'b1;
        model_seed(s);
        exp_q.delete();
        for (int c = 1; c <= WARMUP + 1; c++) begin
            check_flags(1'b0, 1'b1);
            step();
        end
        // The first presented word is the one produced by the WARMUP-th step.
        for (int i = 0; i < WARMUP - 1; i++) void'(model_step());
        exp_q.push_back(model_step());
    endtask

    localparam logic [127:0] SEED_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] SEED_B = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;

    initial begin
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n        = 1'b1;
        seed_valid_i = 1'b0;
        seed_i       = '0;
        rnd_ready_i  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_flags(1'b0, 1'b0);
        check_word(64'h0);
        #9 rst_n = 1'b1;
        step();

        // Unseeded: nothing is ever offered even with ready held high.
        for (int i = 0; i < 100; i++) begin
            rnd_ready_i = 1'b1;
            check_flags(1'b0, 1'b0);
            check_word(64'h0);
            step();
        end

        // All-zero seed, then a long full-throughput stream.
        do_seed(128'h0, 1'b0);
        for (int i = 0; i < 1000; i++) run_cycle(1'b1);

        // Backpressure: held words must neither skip nor repeat.
        for (int i = 0; i < 40; i++) run_cycle(pat[i % 4]);

        // Reseed on a firing cycle, twice with the same seed: the stream restarts identically.
        do_seed(SEED_A, 1'b1);
        for (int i = 0; i < 40; i++) run_cycle(pat[i % 4]);
        do_seed(SEED_A, 1'b1);
        for (int i = 0; i < 40; i++) run_cycle(1'b1);

        // Asynchronous reset between clock edges in the middle of warmup.
        seed_i       = SEED_B;
        seed_valid_i = 1'b1;
        rnd_ready_i  = 1'b0;
        step();
        seed_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_flags(1'b0, 1'b1);
            step();
        end
        #3 rst_n = 1'b0;
        #1;
        check_flags(1'b0, 1'b0);
        check_word(64'h0);
        #2 rst_n = 1'b1;
        exp_q.delete();
        step();
        for (int i = 0; i < 30; i++) begin
            rnd_ready_i = 1'b1;
            check_flags(1'b0, 1'b0);
            check_word(64'h0);
            step();
        end

        // Fresh seed after reset: full latency and stream again.
        do_seed(SEED_B, 1'b0);
        for (int i = 0; i < 40; i++) run_cycle(pat[i % 4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
